// File: rtl/universal_ff_register_if.sv
// Control, data and status bundle for the universal flip-flop register bank.
// The master drives mode/data, and the slave (the register) returns state and count flags.
interface universal_ff_register_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, d, j, k, sin,
    input  q, q_n, tc, wrap
  );

  modport slave (
    input  en, mode, d, j, k, sin,
    output q, q_n, tc, wrap
  );
endinterface

// File: rtl/universal_ff_register.sv
// WIDTH-bit falling-edge register bank: load, JK, toggle, modulo up/down count,
// serial shift and hold, with a look-ahead terminal count and a registered wrap pulse.
module universal_ff_register #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  universal_ff_register_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_UP     = 3'b010,
    MODE_DOWN   = 3'b011,
    MODE_SHL    = 3'b100,
    MODE_SHR    = 3'b101,
    MODE_JK     = 3'b110,
    MODE_TOGGLE = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1'b1);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_next_s;
  logic             tc_s;
  logic             up_wrap_s;
  logic             down_wrap_s;
  logic [WIDTH-1:0] shl_s;
  logic [WIDTH-1:0] shr_s;
  logic [WIDTH-1:0] jk_s;
  mode_e            mode_s;

  assign mode_s = mode_e'(bus.mode);

  // Wrap is decided by MAX_COUNT; out-of-range loaded values count as terminal too.
  assign up_wrap_s   = (q_r >= MAX_COUNT);
  assign down_wrap_s = (q_r == {WIDTH{1'b0}}) || (q_r > MAX_COUNT);

  // Shift forms stay legal for WIDTH=1, where both collapse to q<=sin.
  assign shl_s = (q_r << 1) | WIDTH'(bus.sin);
  assign shr_s = (q_r >> 1) | (WIDTH'(bus.sin) << (WIDTH - 1));
  assign jk_s  = (bus.j & ~q_r) | (~bus.k & q_r);

  // Terminal count: predicts a wrap at the coming falling edge.
  always_comb begin
    tc_s = 1'b0;
    if (reset) begin
      tc_s = 1'b0;
    end else if (bus.en) begin
      case (mode_s)
        MODE_UP:   tc_s = up_wrap_s;
        MODE_DOWN: tc_s = down_wrap_s;
        default:   tc_s = 1'b0;
      endcase
    end else begin
      tc_s = 1'b0;
    end
  end

  // Next-state selection for the whole bank.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    if (bus.en) begin
      case (mode_s)
        MODE_HOLD: q_next_s = q_r;
        MODE_LOAD: q_next_s = bus.d;
        MODE_UP: begin
          if (up_wrap_s) begin
            q_next_s    = {WIDTH{1'b0}};
            wrap_next_s = 1'b1;
          end else begin
            q_next_s = q_r + ONE;
          end
        end
        MODE_DOWN: begin
          if (down_wrap_s) begin
            q_next_s    = MAX_COUNT;
            wrap_next_s = 1'b1;
          end else begin
            q_next_s = q_r - ONE;
          end
        end
        MODE_SHL:    q_next_s = shl_s;
        MODE_SHR:    q_next_s = shr_s;
        MODE_JK:     q_next_s = jk_s;
        MODE_TOGGLE: q_next_s = q_r ^ bus.k;
        default:     q_next_s = q_r;
      endcase
    end else begin
      q_next_s    = q_r;
      wrap_next_s = 1'b0;
    end
  end

  // Bank state: falling-edge update, asynchronous clear.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= {WIDTH{1'b0}};
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  // q_n comes from the same flops, so q^q_n is all ones at every instant.
  assign bus.q    = q_r;
  assign bus.q_n  = ~q_r;
  assign bus.wrap = wrap_r;
  assign bus.tc   = tc_s;

endmodule
